alu: RTL and testbench



---
 rtl/alu.sv | 128 ++++++++++++
 tb/tb_alu.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 32-bit ALU: arithmetic, logic, shift and compare groups selected by ALUFun[5:4].
// Define ALU_FLAGS_EN to add registered Z/V/N flag outputs alongside S.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       ALUFun,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sign,
  output logic [WIDTH-1:0] S
`ifdef ALU_FLAGS_EN
  ,
  output logic             Z,
  output logic             V,
  output logic             N
`endif
);

  logic [WIDTH-1:0]        arith_res;
  logic [WIDTH-1:0]        sra_res;
  logic signed [WIDTH-1:0] b_signed;
  logic [4:0]              shamt;
  logic                    a_zero;
  logic                    a_neg;
  logic                    lt_signed;
  logic                    lt_unsigned;
  logic                    cmp_bit;
  logic [WIDTH-1:0]        s_nxt;

  assign arith_res   = ALUFun[0] ? (A - B) : (A + B);
  assign shamt       = A[4:0];
  assign b_signed    = B;
  assign sra_res     = b_signed >>> shamt;
  assign a_zero      = (A == '0);
  assign a_neg       = A[WIDTH-1];
  assign lt_signed   = $signed(A) < $signed(B);
  assign lt_unsigned = A < B;

  // Zero tests treat A as unsigned magnitude when Sign=0, so "A<0" can never hold.
  always_comb begin
    cmp_bit = 1'b0;
    case (ALUFun[3:1])
      3'b001:  cmp_bit = (A == B);
      3'b000:  cmp_bit = (A != B);
      3'b010:  cmp_bit = Sign ? lt_signed : lt_unsigned;
      3'b110:  cmp_bit = Sign ? (a_neg | a_zero) : a_zero;
      3'b101:  cmp_bit = Sign & a_neg;
      3'b111:  cmp_bit = Sign ? (~a_neg & ~a_zero) : ~a_zero;
      default: cmp_bit = 1'b0;
    endcase
  end

  always_comb begin
    s_nxt = '0;
    case (ALUFun[5:4])
      2'b00: s_nxt = arith_res;
      2'b01: begin
        case (ALUFun[3:0])
          4'b1000: s_nxt = A & B;
          4'b1110: s_nxt = A | B;
          4'b0110: s_nxt = A ^ B;
          4'b0001: s_nxt = ~(A | B);
          4'b1010: s_nxt = A;
          default: s_nxt = '0;
        endcase
      end
      2'b10: begin
        case (ALUFun[1:0])
          2'b00:   s_nxt = B << shamt;
          2'b01:   s_nxt = B >> shamt;
          2'b11:   s_nxt = sra_res;
          default: s_nxt = '0;
        endcase
      end
      default: s_nxt = {{(WIDTH-1){1'b0}}, cmp_bit};
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] arith_ext;
  logic           carry_borrow;
  logic           ovf;
  logic           v_nxt;
  logic           n_nxt;

  // Bit WIDTH of the extended result is carry-out for add and borrow for sub.
  assign arith_ext    = ALUFun[0] ? ({1'b0, A} - {1'b0, B}) : ({1'b0, A} + {1'b0, B});
  assign carry_borrow = arith_ext[WIDTH];
  assign ovf = ALUFun[0]
             ? ((A[WIDTH-1] != B[WIDTH-1]) && (arith_res[WIDTH-1] != A[WIDTH-1]))
             : ((A[WIDTH-1] == B[WIDTH-1]) && (arith_res[WIDTH-1] != A[WIDTH-1]));

  always_comb begin
    v_nxt = 1'b0;
    n_nxt = 1'b0;
    if (ALUFun[5:4] == 2'b00) begin
      if (Sign) begin
        v_nxt = ovf;
        n_nxt = arith_res[WIDTH-1] ^ ovf;
      end else begin
        v_nxt = carry_borrow;
        n_nxt = ALUFun[0] & carry_borrow;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      S <= '0;
`ifdef ALU_FLAGS_EN
      Z <= 1'b0;
      V <= 1'b0;
      N <= 1'b0;
`endif
    end else begin
      S <= s_nxt;
`ifdef ALU_FLAGS_EN
      Z <= (s_nxt == '0);
      V <= v_nxt;
      N <= n_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected results queue on drive, pop and compare one edge later.
// Flag outputs are checked only when ALU_FLAGS_EN is defined.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  alufun = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sign = 1'b0;
  logic [31:0] s;
`ifdef ALU_FLAGS_EN
  logic        z, v, n;
`endif

  int checks = 0;
  int passed = 0;
  logic [31:0] s_q[$];
  logic [2:0]  f_q[$];

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] e;
  } vec_t;

  always #5 clk = ~clk;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .ALUFun (alufun),
    .A      (a),
    .B      (b),
    .Sign   (sign),
    .S      (s)
`ifdef ALU_FLAGS_EN
    ,
    .Z      (z),
    .V      (v),
    .N      (n)
`endif
  );

  function automatic logic [31:0] model(input logic [5:0] f, input logic [31:0] aa,
                                        input logic [31:0] bb, input logic sg);
    logic [4:0] sh;
    logic       c;
    sh = aa[4:0];
    c  = 1'b0;
    case (f[5:4])
      2'b00: return f[0] ? aa - bb : aa + bb;
      2'b01: begin
        case (f[3:0])
          4'b1000: return aa & bb;
          4'b1110: return aa | bb;
          4'b0110: return aa ^ bb;
          4'b0001: return ~(aa | bb);
          4'b1010: return aa;
          default: return 32'h0;
        endcase
      end
      2'b10: begin
        case (f[1:0])
          2'b00:   return bb << sh;
          2'b01:   return bb >> sh;
          2'b11:   return (bb >> sh) | (bb[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
          default: return 32'h0;
        endcase
      end
      default: begin
        case (f[3:1])
          3'b001:  c = (aa == bb);
          3'b000:  c = (aa != bb);
          3'b010:  c = sg ? ((aa ^ 32'h8000_0000) < (bb ^ 32'h8000_0000)) : (aa < bb);
          3'b110:  c = sg ? (aa[31] || aa == 0) : (aa == 0);
          3'b101:  c = sg && aa[31];
          3'b111:  c = sg ? (!aa[31] && aa != 0) : (aa != 0);
          default: return 32'h0;
        endcase
        return {31'b0, c};
      end
    endcase
  endfunction

`ifdef ALU_FLAGS_EN
  // Returns {Z, V, N}, computed with 64-bit arithmetic.
  function automatic logic [2:0] flag_model(input logic [5:0] f, input logic [31:0] aa,
                                            input logic [31:0] bb, input logic sg);
    logic [31:0] r;
    longint      ua, ub, ur, sa, sb, sr;
    logic        ovf, cb;
    r = model(f, aa, bb, sg);
    if (f[5:4] != 2'b00) return {(r == 0), 2'b00};
    ua = longint'(aa);
    ub = longint'(bb);
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    ur = f[0] ? ua - ub : ua + ub;
    sr = f[0] ? sa - sb : sa + sb;
    cb  = f[0] ? (ur < 0) : (ur > 64'sd4294967295);
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    if (sg) return {(r == 0), ovf, r[31] ^ ovf};
    return {(r == 0), cb, f[0] & cb};
  endfunction
`endif

  task automatic apply(input logic rst, input logic [5:0] f, input logic [31:0] aa,
                       input logic [31:0] bb, input logic sg, input logic [31:0] exp);
    @(negedge clk);
    reset  = rst;
    alufun = f;
    a      = aa;
    b      = bb;
    sign   = sg;
    s_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    apply(1'b1, 6'b000000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h0);
    e = s_q.pop_front();
    checks++;
    if (s !== e) $display("FAIL reset_initial got=%h exp=%h", s, e);
    else passed++;
    apply(1'b0, 6'b000000, 32'd13, 32'd33, 1'b0, 32'd46);
    e = s_q.pop_front();
    checks++;
    if (s !== e) $display("FAIL reset_pre_add got=%h exp=%h", s, e);
    else passed++;
    apply(1'b1, 6'b000000, 32'd13, 32'd33, 1'b0, 32'h0);
    e = s_q.pop_front();
    checks++;
    if (s !== e) $display("FAIL reset_midstream got=%h exp=%h", s, e);
    else passed++;
  endtask

  task automatic test_arith();
    vec_t v[6];
    logic [31:0] e;
    v[0] = '{6'b000000, 32'd13, 32'd33, 1'b0, 32'd46};
    v[1] = '{6'b000001, 32'd13, 32'd33, 1'b0, 32'hFFFF_FFEC};
    v[2] = '{6'b000000, 32'd13, 32'd33, 1'b1, 32'd46};
    v[3] = '{6'b000001, 32'd13, 32'd33, 1'b1, 32'hFFFF_FFEC};
    v[4] = '{6'b000000, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0};
    v[5] = '{6'b000001, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, v[i].f, v[i].a, v[i].b, v[i].sg, v[i].e);
      e = s_q.pop_front();
      checks++;
      if (s !== e) $display("FAIL arith[%0d] got=%h exp=%h", i, s, e);
      else passed++;
    end
  endtask

  task automatic test_logic();
    vec_t v[7];
    logic [31:0] e;
    v[0] = '{6'b011000, 32'd13, 32'd33, 1'b0, 32'd1};
    v[1] = '{6'b011110, 32'd13, 32'd33, 1'b0, 32'd45};
    v[2] = '{6'b010110, 32'd13, 32'd33, 1'b1, 32'd44};
    v[3] = '{6'b010001, 32'd13, 32'd33, 1'b0, 32'hFFFF_FFD2};
    v[4] = '{6'b011010, 32'd13, 32'd33, 1'b0, 32'd13};
    v[5] = '{6'b010000, 32'd13, 32'd33, 1'b0, 32'h0};
    v[6] = '{6'b011111, 32'd13, 32'd33, 1'b1, 32'h0};
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, v[i].f, v[i].a, v[i].b, v[i].sg, v[i].e);
      e = s_q.pop_front();
      checks++;
      if (s !== e) $display("FAIL logic[%0d] got=%h exp=%h", i, s, e);
      else passed++;
    end
  endtask

  task automatic test_shift();
    vec_t v[9];
    logic [31:0] e;
    v[0] = '{6'b100011, 32'd13, 32'hF0F0_00FF, 1'b0, 32'hFFFF_8780};
    v[1] = '{6'b100001, 32'd13, 32'hF0F0_00FF, 1'b1, 32'h0007_8780};
    v[2] = '{6'b100000, 32'd13, 32'hF0F0_00FF, 1'b0, 32'h001F_E000};
    v[3] = '{6'b100011, 32'd0,  32'hF0F0_00FF, 1'b0, 32'hF0F0_00FF};
    v[4] = '{6'b100000, 32'hFFFF_FFE0, 32'hF0F0_00FF, 1'b0, 32'hF0F0_00FF};
    v[5] = '{6'b100001, 32'd31, 32'h8000_0000, 1'b0, 32'h0000_0001};
    v[6] = '{6'b100011, 32'd31, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF};
    v[7] = '{6'b100011, 32'hFFFF_FFE4, 32'h7000_0000, 1'b1, 32'h0700_0000};
    v[8] = '{6'b100010, 32'd13, 32'hF0F0_00FF, 1'b0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, v[i].f, v[i].a, v[i].b, v[i].sg, v[i].e);
      e = s_q.pop_front();
      checks++;
      if (s !== e) $display("FAIL shift[%0d] got=%h exp=%h", i, s, e);
      else passed++;
    end
  endtask

  task automatic test_compare();
    vec_t v[18];
    logic [31:0] e;
    v[0]  = '{6'b110101, 32'd13, 32'hF0F0_00FF, 1'b1, 32'd0};
    v[1]  = '{6'b110101, 32'd13, 32'hF0F0_00FF, 1'b0, 32'd1};
    v[2]  = '{6'b110011, 32'hF0F0_00FF, 32'hF0F0_00FF, 1'b0, 32'd1};
    v[3]  = '{6'b111101, 32'hF0F0_00FF, 32'd0, 1'b1, 32'd1};
    v[4]  = '{6'b111101, 32'hF0F0_00FF, 32'd0, 1'b0, 32'd0};
    v[5]  = '{6'b111111, 32'hF0F0_00FF, 32'd0, 1'b1, 32'd0};
    v[6]  = '{6'b111111, 32'hF0F0_00FF, 32'd0, 1'b0, 32'd1};
    v[7]  = '{6'b111011, 32'hF0F0_00FF, 32'd0, 1'b1, 32'd1};
    v[8]  = '{6'b111011, 32'hF0F0_00FF, 32'd0, 1'b0, 32'd0};
    v[9]  = '{6'b110011, 32'd5, 32'd6, 1'b0, 32'd0};
    v[10] = '{6'b110001, 32'd5, 32'd6, 1'b0, 32'd1};
    v[11] = '{6'b110000, 32'd7, 32'd7, 1'b1, 32'd0};
    v[12] = '{6'b110100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'd1};
    v[13] = '{6'b110100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd0};
    v[14] = '{6'b111110, 32'd0, 32'd0, 1'b1, 32'd0};
    v[15] = '{6'b111100, 32'd0, 32'd0, 1'b0, 32'd1};
    v[16] = '{6'b110111, 32'd3, 32'd3, 1'b1, 32'd0};
    v[17] = '{6'b111001, 32'd0, 32'd3, 1'b0, 32'd0};
    for (int i = 0; i < 18; i++) begin
      apply(1'b0, v[i].f, v[i].a, v[i].b, v[i].sg, v[i].e);
      e = s_q.pop_front();
      checks++;
      if (s !== e) $display("FAIL compare[%0d] got=%h exp=%h", i, s, e);
      else passed++;
    end
  endtask

  // Unbroken stream of random operations; operands occasionally forced equal or zero.
  task automatic test_back_to_back();
    logic [5:0]  f;
    logic [31:0] aa, bb, e;
    logic        sg;
    for (int i = 0; i < 300; i++) begin
      f  = 6'($urandom_range(0, 63));
      aa = $urandom;
      bb = $urandom;
      sg = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bb = aa;
      if ($urandom_range(0, 7) == 0) aa = 32'h0;
      apply(1'b0, f, aa, bb, sg, model(f, aa, bb, sg));
      e = s_q.pop_front();
      checks++;
      if (s !== e)
        $display("FAIL back_to_back[%0d] f=%b a=%h b=%h sign=%b got=%h exp=%h",
                 i, f, aa, bb, sg, s, e);
      else passed++;
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    logic [5:0]  f;
    logic [31:0] aa, bb, e;
    logic [2:0]  fe;
    logic        sg;
    for (int i = 0; i < 200; i++) begin
      f  = (i % 2 == 0) ? {4'b0000, 2'($urandom_range(0, 3))} : 6'($urandom_range(0, 63));
      aa = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
      bb = (i % 7 == 0) ? aa : $urandom;
      sg = 1'($urandom_range(0, 1));
      f_q.push_back(flag_model(f, aa, bb, sg));
      apply(1'b0, f, aa, bb, sg, model(f, aa, bb, sg));
      e  = s_q.pop_front();
      fe = f_q.pop_front();
      checks++;
      if (s !== e || {z, v, n} !== fe)
        $display("FAIL flags[%0d] f=%b a=%h b=%h sign=%b got s=%h zvn=%b exp s=%h zvn=%b",
                 i, f, aa, bb, sg, s, {z, v, n}, e, fe);
      else passed++;
    end
    f_q.push_back(3'b000);
    apply(1'b1, 6'b000001, 32'd0, 32'd1, 1'b0, 32'h0);
    e  = s_q.pop_front();
    fe = f_q.pop_front();
    checks++;
    if (s !== e || {z, v, n} !== fe)
      $display("FAIL flags_reset got s=%h zvn=%b exp s=%h zvn=%b", s, {z, v, n}, e, fe);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_compare();
    test_back_to_back();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
